uart_frame_scheduler: RTL

//  Shares one byte-wide UART transmitter between two 16-bit sample sources (ch0 = filtered FIR output,
//  ch1 = raw input sample). Each source has a one-entry holding register. Sources are arbitrated, and each

---
 rtl/uart_frame_scheduler.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/uart_frame_scheduler.sv
// Shares one byte-wide UART transmitter between two 16-bit sample sources, framing each sample
// as header/MSB/LSB. Defining UART_FRAME_CHECKSUM_EN appends an XOR checksum byte to every frame.
module uart_frame_scheduler #(
    parameter logic [3:0]  HDR_NIBBLE = 4'hA,
    parameter int unsigned FIXED_PRIO = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        s0_valid,
    input  logic [15:0] s0_data,
    output logic        s0_ready,
    input  logic        s1_valid,
    input  logic [15:0] s1_data,
    output logic        s1_ready,
    output logic [7:0]  tx_byte,
    output logic        tx_start,
    input  logic        tx_busy,
    output logic        frame_done
);

`ifdef UART_FRAME_CHECKSUM_EN
    localparam int unsigned NBYTES = 4;
`else
    localparam int unsigned NBYTES = 3;
`endif
    localparam logic [1:0] LAST_IDX = 2'(NBYTES - 1);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_START = 3'd2;
    localparam logic [2:0] ST_GUARD = 3'd3;
    localparam logic [2:0] ST_WAIT  = 3'd4;

    logic [2:0]  state_q, state_d;
    logic        hold0_full_q, hold0_full_d;
    logic        hold1_full_q, hold1_full_d;
    logic [15:0] hold0_data_q, hold0_data_d;
    logic [15:0] hold1_data_q, hold1_data_d;
    logic        grant_q, grant_d;
    logic        last_q, last_d;
    logic [15:0] frame_q, frame_d;
    logic        ch_q, ch_d;
    logic [1:0]  idx_q, idx_d;

    logic        pick;
    logic [7:0]  hdr_byte;
    logic [7:0]  chk_byte;
    logic [7:0]  cur_byte;

    assign s0_ready = ~hold0_full_q;
    assign s1_ready = ~hold1_full_q;

    assign hdr_byte = {HDR_NIBBLE, 3'b000, ch_q};
`ifdef UART_FRAME_CHECKSUM_EN
    assign chk_byte = hdr_byte ^ frame_q[15:8] ^ frame_q[7:0];
`else
    assign chk_byte = '0;
`endif

    always_comb begin
        case (idx_q)
            2'd0:    cur_byte = hdr_byte;
            2'd1:    cur_byte = frame_q[15:8];
            2'd2:    cur_byte = frame_q[7:0];
            default: cur_byte = chk_byte;
        endcase
    end

    // Round-robin tie goes to the channel not granted last; a lone request always wins.
    always_comb begin
        if (FIXED_PRIO != 0) begin
            pick = ~hold0_full_q;
        end else if (hold0_full_q && hold1_full_q) begin
            pick = ~last_q;
        end else begin
            pick = hold1_full_q;
        end
    end

    always_comb begin
        state_d      = state_q;
        hold0_full_d = hold0_full_q;
        hold1_full_d = hold1_full_q;
        hold0_data_d = hold0_data_q;
        hold1_data_d = hold1_data_q;
        grant_d      = grant_q;
        last_d       = last_q;
        frame_d      = frame_q;
        ch_d         = ch_q;
        idx_d        = idx_q;
        tx_start     = 1'b0;
        frame_done   = 1'b0;

        if (s0_valid && !hold0_full_q) begin
            hold0_full_d = 1'b1;
            hold0_data_d = s0_data;
        end
        if (s1_valid && !hold1_full_q) begin
            hold1_full_d = 1'b1;
            hold1_data_d = s1_data;
        end

        case (state_q)
            ST_IDLE: begin
                if (hold0_full_q || hold1_full_q) begin
                    grant_d = pick;
                    last_d  = pick;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                frame_d = grant_q ? hold1_data_q : hold0_data_q;
                ch_d    = grant_q;
                idx_d   = '0;
                if (grant_q) begin
                    hold1_full_d = 1'b0;
                end else begin
                    hold0_full_d = 1'b0;
                end
                state_d = ST_START;
            end
            ST_START: begin
                if (!tx_busy) begin
                    tx_start = 1'b1;
                    state_d  = ST_GUARD;
                end
            end
            ST_GUARD: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (!tx_busy) begin
                    if (idx_q == LAST_IDX) begin
                        frame_done = 1'b1;
                        state_d    = ST_IDLE;
                    end else begin
                        idx_d   = idx_q + 2'd1;
                        state_d = ST_START;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign tx_byte = (state_q == ST_START || state_q == ST_GUARD || state_q == ST_WAIT)
                     ? cur_byte : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            hold0_full_q <= 1'b0;
            hold1_full_q <= 1'b0;
            hold0_data_q <= '0;
            hold1_data_q <= '0;
            grant_q      <= 1'b0;
            last_q       <= 1'b1;
            frame_q      <= '0;
            ch_q         <= 1'b0;
            idx_q        <= '0;
        end else begin
            state_q      <= state_d;
            hold0_full_q <= hold0_full_d;
            hold1_full_q <= hold1_full_d;
            hold0_data_q <= hold0_data_d;
            hold1_data_q <= hold1_data_d;
            grant_q      <= grant_d;
            last_q       <= last_d;
            frame_q      <= frame_d;
            ch_q         <= ch_d;
            idx_q        <= idx_d;
        end
    end

endmodule
